// File: rtl/uart_rx_vote_sampler.sv
// Majority-vote bit sampler for an oversampling UART receiver: votes the
// synchronised line over NUM_SAMPLES positions ending at the bit centre.
module uart_rx_vote_sampler #(
    parameter int PRESCALE_W  = 6,
    parameter int NUM_SAMPLES = 3,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  rx_in,
    input  logic                  data_sample_en,
    input  logic [PRESCALE_W-1:0] edge_cnt,
    output logic                  sampled_bit,
    output logic                  data_sampled,
    output logic                  noise_err,
    output logic                  cfg_err
);
    localparam int CNT_W = $clog2(NUM_SAMPLES + 1);
    localparam logic [PRESCALE_W-1:0] SPAN = PRESCALE_W'(NUM_SAMPLES - 1);

    logic rxs;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign rxs = rx_in;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] sync_q, sync_d;

            always_comb begin
                sync_d[0] = rx_in;
                for (int i = 1; i < SYNC_STAGES; i++) begin
                    sync_d[i] = sync_q[i-1];
                end
            end

            // Synchroniser idles high like the line itself.
            always_ff @(posedge clk) begin
                if (rst) sync_q <= '1;
                else     sync_q <= sync_d;
            end

            assign rxs = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    logic [PRESCALE_W-1:0] centre, first_pos;
    logic                  cfg_bad, clear_acc, in_window, at_centre;
    logic [CNT_W-1:0]      ones_q, ones_d, taken_q, taken_d;
    logic [CNT_W-1:0]      vote_ones, vote_taken;
    logic                  armed_q, armed_d, started_q, started_d;
    logic                  sampled_bit_q, sampled_bit_d;
    logic                  noise_err_q, noise_err_d;
    logic                  data_sampled_q, data_sampled_d;
    logic                  cfg_err_q, cfg_err_d;

    always_comb begin
        centre     = prescale >> 1;
        first_pos  = centre - SPAN;
        cfg_bad    = (centre < SPAN) || (prescale < PRESCALE_W'(2));
        clear_acc  = !data_sample_en || (edge_cnt == '0) || cfg_bad;
        in_window  = (edge_cnt >= first_pos) && (edge_cnt < centre);
        at_centre  = (edge_cnt == centre);
        vote_taken = taken_q + CNT_W'(1);
        vote_ones  = ones_q + CNT_W'(rxs);
    end

    // started_q blocks a vote on a bit whose early samples were lost to reset;
    // it is set once the accumulator has seen a genuine clear.
    always_comb begin
        ones_d         = ones_q;
        taken_d        = taken_q;
        started_d      = started_q;
        armed_d        = !at_centre;
        sampled_bit_d  = sampled_bit_q;
        noise_err_d    = noise_err_q;
        data_sampled_d = 1'b0;
        cfg_err_d      = cfg_bad;
        if (clear_acc) begin
            ones_d    = '0;
            taken_d   = '0;
            started_d = 1'b1;
        end else if (in_window) begin
            taken_d = vote_taken;
            ones_d  = vote_ones;
        end else if (at_centre && armed_q && started_q) begin
            sampled_bit_d  = ({1'b0, vote_ones} << 1) > {1'b0, vote_taken};
            noise_err_d    = (vote_ones != '0) && (vote_ones != vote_taken);
            data_sampled_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ones_q         <= '0;
            taken_q        <= '0;
            armed_q        <= 1'b1;
            started_q      <= 1'b0;
            sampled_bit_q  <= 1'b0;
            noise_err_q    <= 1'b0;
            data_sampled_q <= 1'b0;
            cfg_err_q      <= 1'b0;
        end else begin
            ones_q         <= ones_d;
            taken_q        <= taken_d;
            armed_q        <= armed_d;
            started_q      <= started_d;
            sampled_bit_q  <= sampled_bit_d;
            noise_err_q    <= noise_err_d;
            data_sampled_q <= data_sampled_d;
            cfg_err_q      <= cfg_err_d;
        end
    end

    assign sampled_bit  = sampled_bit_q;
    assign data_sampled = data_sampled_q;
    assign noise_err    = noise_err_q;
    assign cfg_err      = cfg_err_q;

endmodule
